// File: rtl/signed_mult_seq_ctrl_pkg.sv
// Shared types and defaults for the sequential signed (Booth) multiplier.
package signed_mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/signed_mult_seq_ctrl_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then an
// arithmetic right shift of the combined {A, Q, q_m1} register.
module booth_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum_s;

    // Booth recoding of {Q[0], q_m1} selects add, subtract or pass
    always_comb begin
        sum_s = acc;
        case ({q[0], q_m1})
            2'b01:   sum_s = acc + m;
            2'b10:   sum_s = acc - m;
            default: sum_s = acc;
        endcase
    end

    // Arithmetic shift keeps the accumulator sign bit
    always_comb begin
        acc_next  = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_next    = {sum_s[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/signed_mult_seq_ctrl.sv
// Sequential signed multiplier controller: valid/ready operand intake,
// WIDTH Booth steps, then a held result with a narrow-range overflow flag.
module signed_mult_seq_ctrl
    import signed_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow,
    output logic                 busy
);

    state_e               state_r;
    state_e               state_s;
    logic [WIDTH:0]       m_r;
    logic [WIDTH:0]       acc_r;
    logic [WIDTH-1:0]     q_r;
    logic                 qm1_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 overflow_r;

    logic [WIDTH:0]       acc_nxt_s;
    logic [WIDTH-1:0]     q_nxt_s;
    logic                 qm1_nxt_s;
    logic [2*WIDTH-1:0]   prod_nxt_s;
    logic                 accept_s;
    logic                 last_step_s;
    logic                 res_hs_s;

    // True when the product does not sign-extend from WIDTH bits
    function automatic logic prod_overflow(input logic [2*WIDTH-1:0] p);
        logic [WIDTH:0] top_s;
        top_s = p[2*WIDTH-1:WIDTH-1];
        return !((top_s == {(WIDTH+1){1'b0}}) || (top_s == {(WIDTH+1){1'b1}}));
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc_r),
        .q         (q_r),
        .q_m1      (qm1_r),
        .m         (m_r),
        .acc_next  (acc_nxt_s),
        .q_next    (q_nxt_s),
        .q_m1_next (qm1_nxt_s)
    );

    assign accept_s    = (state_r == IDLE) && start_valid;
    assign last_step_s = (state_r == CALC) && (cnt_r == CNT_W'(WIDTH - 1));
    assign res_hs_s    = (state_r == DONE) && res_ready;
    assign prod_nxt_s  = {acc_nxt_s[WIDTH-1:0], q_nxt_s};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CALC;
                else          state_s = IDLE;
            end
            CALC: begin
                if (last_step_s) state_s = DONE;
                else             state_s = CALC;
            end
            DONE: begin
                if (res_hs_s) state_s = IDLE;
                else          state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        res_valid   = 1'b0;
        case (state_r)
            IDLE:    start_ready = 1'b1;
            CALC:    busy        = 1'b1;
            DONE:    res_valid   = 1'b1;
            default: start_ready = 1'b0;
        endcase
    end

    // Booth datapath, step counter and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r        <= {(WIDTH+1){1'b0}};
            acc_r      <= {(WIDTH+1){1'b0}};
            q_r        <= {WIDTH{1'b0}};
            qm1_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            product_r  <= {(2*WIDTH){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        m_r   <= {a[WIDTH-1], a};
                        acc_r <= {(WIDTH+1){1'b0}};
                        q_r   <= b;
                        qm1_r <= 1'b0;
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                CALC: begin
                    acc_r <= acc_nxt_s;
                    q_r   <= q_nxt_s;
                    qm1_r <= qm1_nxt_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        product_r  <= prod_nxt_s;
                        overflow_r <= prod_overflow(prod_nxt_s);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign product  = product_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_signed_mult_seq_ctrl.sv
// Scoreboard bench for signed_mult_seq_ctrl at WIDTH=4.
module tb_signed_mult_seq_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [2*W-1:0] product;
    logic           overflow;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_results = 0;
    int n_pushed  = 0;
    logic [2*W:0] sb_q[$];

    signed_mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b),
        .res_valid(res_valid), .res_ready(res_ready),
        .product(product), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int p;
        logic [2*W-1:0] pb;
        logic ov;
        p  = int'($signed(x)) * int'($signed(y));
        pb = p[2*W-1:0];
        ov = (p < -(1 << (W-1))) || (p > (1 << (W-1)) - 1);
        return {ov, pb};
    endfunction

    // Scoreboard: each completed handshake must match the oldest pending op
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            logic [2*W:0] e;
            n_results++;
            check_eq("result_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("product", 32'(product), 32'(e[2*W-1:0]));
                check_eq("overflow", 32'(overflow), 32'(e[2*W]));
            end
        end
    end

    // Called at posedge+1; returns at accept edge +1
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_res);
        int guard = 0;
        while (!start_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("start_ready_wait", 32'(guard < 100), 32'd1);
        a = x; b = y; start_valid = 1'b1;
        if (expect_res) begin
            sb_q.push_back(model(x, y));
            n_pushed++;
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
    endtask

    task automatic check_latency(input string tag);
        int lat = 0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_ready_low"}, 32'(start_ready), 32'd0);
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(W));
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((sb_q.size() > 0 || !start_ready) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq({tag, "_drained"}, 32'(guard < 200), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_product"}, 32'(product), 32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_reset_outputs("reset");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed products with latency checks
        send(4'd3, 4'hE, 1'b1);  check_latency("op_3xm2");  drain("op_3xm2");
        send(4'h8, 4'h8, 1'b1);  check_latency("op_m8xm8"); drain("op_m8xm8");
        send(4'd7, 4'd7, 1'b1);  check_latency("op_7x7");   drain("op_7x7");
        send(4'h8, 4'd1, 1'b1);  check_latency("op_m8x1");  drain("op_m8x1");
        send(4'd0, 4'hB, 1'b1);  check_latency("op_0xm5");  drain("op_0xm5");

        // Back-pressure hold, with an ignored start pulse
        res_ready = 1'b0;
        send(4'd2, 4'd3, 1'b1);
        check_latency("bp");
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid_hold", 32'(res_valid), 32'd1);
            check_eq("bp_product_hold", 32'(product), 32'h06);
            check_eq("bp_start_ready", 32'(start_ready), 32'd0);
            start_valid = (i == 4);
            a = 4'd1; b = 4'd1;
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_valid", 32'(res_valid), 32'd0);
        check_eq("bp_release_idle", 32'(start_ready), 32'd1);
        repeat (8) begin @(posedge clk); #1; end
        check_eq("bp_no_extra_op", 32'(start_ready), 32'd1);

        // Reset in the middle of a calculation discards the op
        send(4'd5, 4'd5, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'hF, 4'hF, 1'b1); check_latency("after_rst"); drain("after_rst");

        // Exhaustive back-to-back sweep
        for (int i = 0; i < 256; i++) begin
            send(W'(i >> 4), W'(i & 15), 1'b1);
        end
        drain("sweep");
        repeat (10) begin @(posedge clk); #1; end
        check_eq("result_count", 32'(n_results), 32'(n_pushed));
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
